// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (A) and the
// loader/DMA engine (B), with a bounded lock window for atomic read-modify-write.
module mem_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int LOCK_MAX = 16
) (
   input  logic          clk,
   input  logic          Reset,
   input  logic          a_req,
   input  logic          a_we,
   input  logic          a_lock,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic          b_lock,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          ReadMem,
   output logic          WriteMem,
   output logic [AW-1:0] DataAddress,
   output logic [DW-1:0] DataIn,
   input  logic [DW-1:0] DataOut
);
   localparam int CW = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] LCNT_LAST = CW'(LOCK_MAX - 1);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

   state_t        state_q, state_d;
   logic          last_b_q, last_b_d;   // 1 = B won most recently, so A wins the next tie
   logic [CW-1:0] lcnt_q, lcnt_d;
   logic [CW-1:0] lcnt_inc;
   logic          a_rvalid_q, a_rvalid_d;
   logic          b_rvalid_q, b_rvalid_d;
   logic [DW-1:0] a_rdata_q, a_rdata_d;
   logic [DW-1:0] b_rdata_q, b_rdata_d;

   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (!Reset) begin
         case (state_q)
            OWN_A:   a_gnt = a_req;
            OWN_B:   b_gnt = b_req;
            default: begin
               if (a_req && (!b_req || last_b_q)) a_gnt = 1'b1;
               else                               b_gnt = b_req;
            end
         endcase
      end
   end

   always_comb begin
      ReadMem     = 1'b0;
      WriteMem    = 1'b0;
      DataAddress = '0;
      DataIn      = '0;
      if (a_gnt) begin
         ReadMem     = ~a_we;
         WriteMem    = a_we;
         DataAddress = a_addr;
         DataIn      = a_wdata;
      end else if (b_gnt) begin
         ReadMem     = ~b_we;
         WriteMem    = b_we;
         DataAddress = b_addr;
         DataIn      = b_wdata;
      end
   end

   assign lcnt_inc = lcnt_q + CW'(1);

   always_comb begin
      state_d    = state_q;
      last_b_d   = last_b_q;
      lcnt_d     = lcnt_q;
      a_rvalid_d = a_gnt && !a_we;
      b_rvalid_d = b_gnt && !b_we;
      a_rdata_d  = a_rvalid_d ? DataOut : a_rdata_q;
      b_rdata_d  = b_rvalid_d ? DataOut : b_rdata_q;
      if (a_gnt)      last_b_d = 1'b0;
      else if (b_gnt) last_b_d = 1'b1;

      case (state_q)
         OWN_A: begin
            lcnt_d = lcnt_inc;
            // Release or timeout both leave A as the latest owner, so B wins the next tie
            if ((a_gnt && !a_lock) || lcnt_inc == LCNT_LAST) begin
               state_d  = IDLE;
               lcnt_d   = '0;
               last_b_d = 1'b0;
            end
         end
         OWN_B: begin
            lcnt_d = lcnt_inc;
            if ((b_gnt && !b_lock) || lcnt_inc == LCNT_LAST) begin
               state_d  = IDLE;
               lcnt_d   = '0;
               last_b_d = 1'b1;
            end
         end
         default: begin
            if (a_gnt && a_lock) begin
               state_d = OWN_A;
               lcnt_d  = '0;
            end else if (b_gnt && b_lock) begin
               state_d = OWN_B;
               lcnt_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         last_b_q   <= 1'b1;
         lcnt_q     <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_b_q   <= last_b_d;
         lcnt_q     <= lcnt_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
      end
   end

   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;
endmodule
